// File: rtl/pipe_scroller.sv
// pipe_scroller
// Holds the horizontal position and gap height of the four pipe obstacles.
// On start, the initial x of each pipe is read from an external ROM, one
// pipe per cycle. After that, each frame_tick scrolls every pipe left by
// SPEED, one pipe per cycle. A pipe that would move past the left edge is
// wrapped to the right by SCREEN_W and given a fresh pseudo-random gap.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   reset        synchronous, active-high reset
//   start        one-cycle pulse that (re)loads the initial positions
//   frame_tick   one-cycle pulse per video frame
//   rom_idx      index driven to the initial-position ROM while loading
//   rom_data     combinational ROM output for rom_idx
//   pipe_sel     read-port pipe select
//   pipe_x       x of the selected pipe (combinational from registers)
//   pipe_gap_y   gap top of the selected pipe (combinational from registers)
//   ready        positions are valid (RUN or UPDATE)
//   busy         loading or updating (LOAD or UPDATE)
//   score_pulse  one-cycle pulse when a pipe crosses BIRD_X
module pipe_scroller #(
  parameter int SCREEN_W = 640,
  parameter int SPEED    = 2,
  parameter int BIRD_X   = 100,
  parameter int GAP_MIN  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  output logic [1:0] rom_idx,
  input  logic [9:0] rom_data,
  input  logic [1:0] pipe_sel,
  output logic [9:0] pipe_x,
  output logic [8:0] pipe_gap_y,
  output logic       ready,
  output logic       busy,
  output logic       score_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_UPDATE} state_t;

  localparam logic [10:0] SPEED_W  = 11'(SPEED);
  localparam logic [10:0] SCREEN_X = 11'(SCREEN_W);
  localparam logic [10:0] BIRD_W   = 11'(BIRD_X);
  localparam logic [8:0]  GAP_BASE = 9'(GAP_MIN);

  state_t      r_state, w_state_next;
  logic [1:0]  r_k, w_k_next;
  logic        r_pending, w_pending_next;
  logic [7:0]  r_lfsr;
  logic [9:0]  r_x   [4];
  logic [8:0]  r_gap [4];
  logic        r_score;

  logic        w_load_we;
  logic        w_upd_we;
  logic [9:0]  w_x_old;
  logic        w_wrap;
  logic [10:0] w_x_sum;
  logic        w_cross;
  logic [8:0]  w_gap_rand;

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  // Step arithmetic for the pipe pointed to by k. The work is done at
  // 11 bits so the wrap case (x - SPEED + SCREEN_W) never underflows.
  always_comb begin
    w_x_old    = r_x[r_k];
    w_wrap     = ({1'b0, w_x_old} < SPEED_W);
    w_x_sum    = {1'b0, w_x_old} - SPEED_W + (w_wrap ? SCREEN_X : 11'd0);
    // A wrapped pipe lands on the right edge, so it can never score.
    w_cross    = !w_wrap && ({1'b0, w_x_old} >= BIRD_W) && (w_x_sum < BIRD_W);
    w_gap_rand = GAP_BASE + {2'b00, r_lfsr[6:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_k       <= 2'd0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_k       <= w_k_next;
      r_pending <= w_pending_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_k_next       = r_k;
    w_pending_next = r_pending;
    w_load_we      = 1'b0;
    w_upd_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_LOAD;
          w_k_next     = 2'd0;
        end
      end
      S_LOAD: begin
        w_load_we = 1'b1;
        w_k_next  = r_k + 2'd1;
        if (r_k == 2'd3) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (start) begin
          w_state_next = S_LOAD;
          w_k_next     = 2'd0;
        end else if (frame_tick) begin
          w_state_next = S_UPDATE;
          w_k_next     = 2'd0;
        end
      end
      S_UPDATE: begin
        if (start) begin
          // Abort the sweep; the reload overwrites every pipe anyway.
          w_state_next   = S_LOAD;
          w_k_next       = 2'd0;
          w_pending_next = 1'b0;
        end else begin
          w_upd_we = 1'b1;
          w_k_next = r_k + 2'd1;
          if (r_k == 2'd3) begin
            // A tick that lands on the last pipe counts as queued too.
            // If a tick is already pending, this one is dropped.
            if (r_pending || frame_tick) begin
              w_state_next   = S_UPDATE;
              w_pending_next = 1'b0;
            end else begin
              w_state_next = S_RUN;
            end
          end else if (frame_tick) begin
            w_pending_next = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_x[i]   <= 10'd0;
        r_gap[i] <= 9'd0;
      end
      r_score <= 1'b0;
    end else begin
      r_score <= w_upd_we && w_cross;
      if (w_load_we) begin
        r_x[r_k]   <= rom_data;
        r_gap[r_k] <= w_gap_rand;
      end
      if (w_upd_we) begin
        r_x[r_k] <= w_x_sum[9:0];
        if (w_wrap) begin
          r_gap[r_k] <= w_gap_rand;
        end
      end
    end
  end

  assign rom_idx     = (r_state == S_LOAD) ? r_k : 2'd0;
  assign pipe_x      = r_x[pipe_sel];
  assign pipe_gap_y  = r_gap[pipe_sel];
  assign ready       = (r_state == S_RUN) || (r_state == S_UPDATE);
  assign busy        = (r_state == S_LOAD) || (r_state == S_UPDATE);
  assign score_pulse = r_score;

endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller
// Self-checking bench for pipe_scroller. The reference model keeps plain
// integer pipe positions and applies whole frames at a time. It predicts
// the positions after each frame, the busy length, and which update slots
// carry a score pulse.
module tb_pipe_scroller;

  localparam int SCREEN_W = 640;
  localparam int SPEED    = 2;
  localparam int BIRD_X   = 100;
  localparam int GAP_MIN  = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] rom_idx;
  logic [9:0] rom_data;
  logic [1:0] pipe_sel = 2'd0;
  logic [9:0] pipe_x;
  logic [8:0] pipe_gap_y;
  logic       ready;
  logic       busy;
  logic       score_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int mx [4];

  always #5 clk = ~clk;

  // Initial-position ROM: pipes evenly spaced 160 px apart.
  assign rom_data = 10'(rom_idx) * 10'd160;

  pipe_scroller #(
    .SCREEN_W(SCREEN_W), .SPEED(SPEED), .BIRD_X(BIRD_X), .GAP_MIN(GAP_MIN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .rom_idx(rom_idx), .rom_data(rom_data), .pipe_sel(pipe_sel),
    .pipe_x(pipe_x), .pipe_gap_y(pipe_gap_y), .ready(ready), .busy(busy),
    .score_pulse(score_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0d", tag, got);
    end
  endtask

  // One screen step of a pipe, from the game rules: move left, and
  // reappear at the right edge once it would leave the screen.
  function automatic int next_x(input int x);
    if (x >= SPEED) return x - SPEED;
    return x - SPEED + SCREEN_W;
  endfunction

  task automatic model_frame(output logic [3:0] m);
    m = 4'b0;
    for (int p = 0; p < 4; p++) begin
      int o;
      int n;
      o = mx[p];
      n = next_x(o);
      if (o >= BIRD_X && n < BIRD_X) m[p] = 1'b1;
      mx[p] = n;
    end
  endtask

  task automatic model_load();
    for (int p = 0; p < 4; p++) mx[p] = p * 160;
  endtask

  task automatic check_pipes(input string tag);
    for (int p = 0; p < 4; p++) begin
      pipe_sel = 2'(p);
      #1;
      check($sformatf("%s_x%0d", tag, p), 32'(pipe_x), 32'(mx[p]));
      check($sformatf("%s_gap%0d", tag, p),
            32'((pipe_gap_y >= GAP_MIN) && (pipe_gap_y <= GAP_MIN + 127)), 32'd1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_load(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("%s_idx%0d", tag, j), 32'(rom_idx), 32'(j));
      check($sformatf("%s_busy%0d", tag, j), 32'(busy), 32'd1);
      check($sformatf("%s_nrdy%0d", tag, j), 32'(ready), 32'd0);
      @(posedge clk); #1;
    end
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    model_load();
    check_pipes(tag);
  endtask

  // Issue one frame tick. extra[i] drives an additional tick that is
  // sampled i+1 edges after the first one. Any extra tick queues exactly
  // one more frame, and further ticks are dropped.
  task automatic run_frames(input string tag, input logic [3:0] extra);
    logic [7:0] mask;
    logic [7:0] exp_mask;
    logic [3:0] m0;
    logic [3:0] m1;
    int bcnt;
    int stray;
    int frames;
    bit done;
    mask = 8'd0; bcnt = 0; stray = 0; done = 1'b0;
    frame_tick = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      frame_tick = (i < 4) ? extra[i[1:0]] : 1'b0;
      if (busy) bcnt++;
      if (score_pulse) begin
        if (i >= 1 && i <= 8) mask[i-1] = 1'b1;
        else stray++;
      end
      if (i >= 1 && !busy) done = 1'b1;
    end
    frame_tick = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    frames = (extra != 4'd0) ? 2 : 1;
    model_frame(m0);
    m1 = 4'd0;
    if (frames == 2) model_frame(m1);
    exp_mask = {m1, m0};
    check({tag, "_busy"}, 32'(bcnt), 32'(4 * frames));
    check({tag, "_score"}, 32'(mask), 32'(exp_mask));
    check({tag, "_stray"}, 32'(stray), 32'd0);
    check_pipes(tag);
  endtask

  initial begin
    int pulses;
    int exp_pulses;
    int bcnt;

    // Reset state
    reset = 1'b1;
    idle(2);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_score", 32'(score_pulse), 32'd0);
    check("rst_idx", 32'(rom_idx), 32'd0);
    check("rst_x0", 32'(pipe_x), 32'd0);
    check("rst_gap0", 32'(pipe_gap_y), 32'd0);
    reset = 1'b0;

    // IDLE ignores frame_tick
    frame_tick = 1'b1;
    idle(1);
    frame_tick = 1'b0;
    idle(1);
    check("idle_tick_busy", 32'(busy), 32'd0);
    check("idle_tick_ready", 32'(ready), 32'd0);

    do_load("load");

    // First tick: pipe 0 wraps to 638 and gets a new gap.
    run_frames("tick1", 4'd0);

    // Ticks 2..31 with random spacing; tick 31 takes pipe 1 past the bird.
    for (int n = 2; n <= 31; n++) begin
      idle($urandom_range(0, 4));
      run_frames($sformatf("tick%0d", n), 4'd0);
    end
    pipe_sel = 2'd1;
    #1;
    check("score_x1_after31", 32'(pipe_x), 32'd98);

    // Back-to-back: ticks 2 and 3 edges after the first; the third is dropped.
    idle(1);
    run_frames("b2b", 4'b0110);

    // start during UPDATE, with a pending tick that must be discarded.
    idle(2);
    pulses = 0;
    exp_pulses = (mx[0] >= BIRD_X && next_x(mx[0]) < BIRD_X) ? 1 : 0;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    if (score_pulse) pulses++;
    @(posedge clk); #1;
    if (score_pulse) pulses++;
    frame_tick = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (score_pulse) pulses++;
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_nrdy", 32'(ready), 32'd0);
    check("abort_idx", 32'(rom_idx), 32'd0);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      if (score_pulse) pulses++;
    end
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_pulses", 32'(pulses), 32'(exp_pulses));
    model_load();
    check_pipes("abort");
    run_frames("post_abort", 4'd0);

    // Random spacing and random overlapping ticks.
    for (int n = 0; n < 20; n++) begin
      idle($urandom_range(0, 6));
      run_frames($sformatf("rnd%0d", n), 4'($urandom_range(0, 15)));
    end

    // reset mid-LOAD
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rml_ready", 32'(ready), 32'd0);
    check("rml_busy", 32'(busy), 32'd0);
    check("rml_idx", 32'(rom_idx), 32'd0);
    check("rml_score", 32'(score_pulse), 32'd0);
    for (int p = 0; p < 4; p++) begin
      pipe_sel = 2'(p);
      #1;
      check($sformatf("rml_x%0d", p), 32'(pipe_x), 32'd0);
      check($sformatf("rml_gap%0d", p), 32'(pipe_gap_y), 32'd0);
    end
    // Still in IDLE: a tick must not start an update.
    bcnt = 0;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
    check("rml_idle_busy", 32'(bcnt), 32'd0);

    do_load("reload");
    run_frames("recover", 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_scroller.md
# pipe_scroller

Owns the horizontal state of the four pipe obstacles in the game-logic layer. It reads the initial-position ROM by index at game start, then scrolls every pipe left once per video frame. Pipes that leave the screen are recycled to the right edge with a fresh pseudo-random gap height. Pipe positions are exposed through an indexed read port, and a one-cycle score pulse fires whenever a pipe passes the bird column. Downstream consumers are the renderer and the collision checker.

## Interface

Parameters:

- SCREEN_W, 640: wrap span in pixels; recycled x = x − SPEED + SCREEN_W.
- SPEED, 2: pixels moved per frame tick; legal range 1..15.
- BIRD_X, 100: column used for score detection.
- GAP_MIN, 60: minimum gap top y; gap_y = GAP_MIN + lfsr[6:0].

Ports:

- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse that (re)loads initial positions.
- frame_tick, input, 1: one-cycle pulse per video frame.
- rom_idx, output, 2: index driven to the initial-position ROM.
- rom_data, input, 10: combinational ROM output for rom_idx.
- pipe_sel, input, 2: read-port pipe select.
- pipe_x, output, 10: x of the selected pipe; combinational from registers.
- pipe_gap_y, output, 9: gap top of the selected pipe; combinational from registers.
- ready, output, 1: positions are valid (RUN or UPDATE).
- busy, output, 1: high in LOAD or UPDATE.
- score_pulse, output, 1: one-cycle pulse when a pipe crosses BIRD_X.

## Operation

- **State machine:** IDLE, LOAD, RUN, UPDATE. There is a 2-bit pointer k and an 8-bit LFSR (x^8+x^6+x^5+x^4+1). The LFSR advances every cycle and is seeded with 8'hA5 at reset.
- **IDLE:**
  - start → LOAD with k=0.
  - frame_tick is ignored.
- **LOAD:**
  - rom_idx = k.
  - Each cycle: x[k] ← rom_data, gap[k] ← GAP_MIN + lfsr[6:0], then k++.
  - After k=3 → RUN.
  - frame_tick is ignored.
- **RUN:**
  - frame_tick → UPDATE with k=0.
  - start → LOAD with k=0; start has priority over a simultaneous frame_tick.
- **UPDATE:** one pipe per cycle, k=0..3.
  - If x[k] < SPEED: x[k] ← x[k] − SPEED + SCREEN_W, and gap[k] is reloaded from the LFSR.
  - Otherwise: x[k] ← x[k] − SPEED.
  - score_pulse = 1 in that cycle iff old x[k] ≥ BIRD_X and new x[k] < BIRD_X; a wrap never scores.
  - After k=3: → UPDATE again if pending is set (pending is cleared on re-entry), otherwise → RUN.
- **Overlapping ticks:** a frame_tick arriving during UPDATE sets pending. At most one tick is queued; further ticks are dropped.
- **start during UPDATE:** abort the update, clear pending, go to LOAD with k=0.
- **Arithmetic:** use 11-bit internal subtraction/addition, truncated to 10 bits on store. Stored x is always < SCREEN_W after the first update.
- **Status outputs:** ready = (state==RUN or UPDATE); busy = (state==LOAD or UPDATE).

## Timing

- **Reset values:**
  - state IDLE, k=0, pending=0.
  - all x and gap registers 0.
  - rom_idx=0, ready=0, busy=0, score_pulse=0.
- **reset mid-operation:** on the next edge, forces all reset values regardless of state. reset dominates start and frame_tick.
- **Load latency:** start sampled at edge t.
  - LOAD occupies edges t+1..t+4 (k=0..3).
  - ready=1 from the cycle after edge t+4.
- **Update latency:** frame_tick sampled in RUN at edge t.
  - Pipe k is updated at edge t+1+k.
  - A new pipe_x is visible after that edge.
  - score_pulse is registered and is high for exactly the cycle following edge t+1+k.
- **Read port:** pipe_x and pipe_gap_y follow pipe_sel in the same cycle, with zero latency.
- **Minimum tick spacing without queuing:** 5 cycles.

## Test plan

- **Reset then load:** reset high 2 cycles, then start pulse → ready rises 5 cycles after start; x = 0, 160, 320, 480 for sel 0..3; rom_idx sequenced 0,1,2,3.
- **Single tick, SPEED=2:** one frame_tick after load → x = 638, 158, 318, 478. Pipe 0 gap reloaded and in the range 60..187. busy high for exactly 4 cycles.
- **Scoring:** 30 ticks → pipe 1 x=100 with no pulse; 31st tick → x=98 and exactly one score_pulse, in pipe 1's update cycle. Pipe 0's wrap (0→638) produces no pulse.
- **Back-to-back ticks:** a tick 2 cycles after a previous tick → second update runs immediately afterwards (8 consecutive busy cycles). A third tick within the same window is dropped; positions decrease by exactly 4.
- **start during UPDATE:** positions return to 0/160/320/480, pending is cleared, and no score pulse occurs.
- **reset mid-LOAD:** all outputs return to 0 on the next edge, and the state is IDLE.
